regwrite_arbiter: RTL and testbench
===================================

// Module: regwrite_arbiter
// PURPOSE
//   Write-back stage directly upstream of the 32x32 register file; sole driver of its write port.
//   Merges two write sources into the single WriteRegister/WriteData/RegWrite port:
//   - CPU pipeline results, which have priority;
//   - keyboard-input device loads, buffered in a small FIFO.
//   Outputs are registered, with one cycle of latency.
// PARAMETERS
//   DEPTH         4   keyboard FIFO entries (power of 2, >=2)
//   STARVE_LIMIT  8   consecutive lost arbitrations before keyboard is forced (macro only)
// PORTS
//   Clk               in   1   clock, posedge
//   Reset_n           in   1   reset, synchronous, active-low
//   CpuWriteValid     in   1   CPU write request; no backpressure except CpuStall
//   CpuWriteRegister  in   5   CPU destination register
//   CpuWriteData      in   32  CPU write data
//   CpuStall          out  1   CPU must hold its request this cycle (0 unless macro)
//   KeyValid          in   1   keyboard entry offered
//   KeyReady          out  1   FIFO can accept; transfer when KeyValid&&KeyReady
//   KeyRegister       in   5   keyboard destination register
//   KeyData           in   32  keyboard data
//   KeyCount          out  clog2(DEPTH)+1  FIFO occupancy
//   WriteRegister     out  5   to regfile
//   WriteData         out  32  to regfile
//   RegWrite          out  1   to regfile write enable
// BEHAVIOUR
//   Clocking and reset:
//   - One clock (Clk).
//   - Reset is synchronous and active-low (Reset_n). While Reset_n=0 at posedge:
//     FIFO is flushed, KeyCount=0, RegWrite=0, WriteRegister=0, WriteData=0, starve counter=0.
//   - KeyReady=0 and CpuStall=0 while Reset_n=0; reset mid-queue discards all entries.
//   Arbitration, evaluated each cycle, result registered at next posedge:
//   1. CpuWriteValid && !CpuStall && CpuWriteRegister!=0 -> issue CPU write.
//   2. Else if FIFO non-empty -> pop head, issue keyboard write.
//   3. Else RegWrite<=0; WriteRegister/WriteData hold their previous value.
//   Register 0:
//   - A CPU write to r0 is dropped and does not win arbitration, so the FIFO may drain that cycle.
//   - A keyboard entry to r0 completes its handshake but is never stored.
//   - RegWrite is never asserted with WriteRegister=0.
//   FIFO:
//   - KeyReady = (KeyCount < DEPTH), derived from registered count only. A pop in the same
//     cycle does not raise it, so push-when-full is impossible.
//   - An entry pushed into an empty FIFO is poppable next cycle at the earliest, giving
//     KeyValid->RegWrite of 2 cycles minimum.
//   - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
//   - Entries issue in strict push order.
//   - No ordering exists between sources: a later CPU write to the same register may land
//     before an older queued key entry. Software resolves this.
// CONFIGURATION
//   REGWRITE_STARVE_GUARD_EN defined:
//   - The starve counter increments each cycle the FIFO is non-empty and a CPU write wins;
//     it clears when a key entry issues or the FIFO is empty.
//   - While counter==STARVE_LIMIT: CpuStall=1 (combinational from the registered counter),
//     the key head issues, and the counter clears.
//   - The CPU holds its request and it issues next cycle.
//   REGWRITE_STARVE_GUARD_EN undefined:
//   - No counter; CpuStall tied 0; keyboard entries wait indefinitely behind the CPU.
// STRUCTURE
//   Shared header regwrite_defs.vh:
//   - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0, KEY_ENTRY_W=37 (register+data packing).
//   Sub-module regwrite_fifo:
//   - Parameterised DEPTH x KEY_ENTRY_W synchronous FIFO with count, push/pop, full/empty.
//   Top level holds the arbiter, starve counter and output registers.
// TESTING
//   1. Reset_n=0 for 2 cycles with KeyValid=1, CpuWriteValid=1 -> RegWrite=0, KeyReady=0,
//      KeyCount=0, outputs 0.
//   2. CPU write r2=15 at cycle t -> at t+1 RegWrite=1, WriteRegister=2, WriteData=15;
//      regfile then reads 15 on both ports.
//   3. Key write r10=8 at t, no CPU traffic -> KeyCount=1 at t+1; RegWrite with r10/8 at t+2;
//      KeyCount=0 at t+2.
//   4. CPU writes r3 continuously; offer 5 key entries -> KeyReady drops after the 4th,
//      KeyCount=4, 5th held. On CPU release, 5 writes appear in push order on consecutive cycles.
//   5. FIFO holds r4=4; CPU writes r0=8 -> key entry issues the next cycle; no RegWrite with
//      WriteRegister=0 during the entire test.
//   6. With macro, STARVE_LIMIT=8, CPU continuously valid, 1 key entry queued -> CpuStall=1 in
//      exactly the 9th contended cycle, key written, CPU write follows. Without macro
//      CpuStall=0 throughout and KeyCount stays 1.

Source files
------------

// File: rtl/regwrite_arbiter_pkg.sv
// regwrite_arbiter_pkg: register-file write-port widths and keyboard FIFO entry packing.
package regwrite_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int KEY_ENTRY_W = REG_ADDR_W + REG_DATA_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } key_entry_t;
endpackage

// File: rtl/regwrite_arbiter_fifo.sv
// regwrite_arbiter_fifo: DEPTH x W synchronous FIFO with occupancy count, active-low sync reset.
module regwrite_arbiter_fifo
  import regwrite_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = KEY_ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: merges CPU results (priority) and queued keyboard loads onto the regfile write port.
// Optional keyboard starvation guard enabled by defining REGWRITE_STARVE_GUARD_EN.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef REGWRITE_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   CpuWriteValid,
  input  logic [REG_ADDR_W-1:0]  CpuWriteRegister,
  input  logic [REG_DATA_W-1:0]  CpuWriteData,
  output logic                   CpuStall,
  input  logic                   KeyValid,
  output logic                   KeyReady,
  input  logic [REG_ADDR_W-1:0]  KeyRegister,
  input  logic [REG_DATA_W-1:0]  KeyData,
  output logic [$clog2(DEPTH):0] KeyCount,
  output logic [REG_ADDR_W-1:0]  WriteRegister,
  output logic [REG_DATA_W-1:0]  WriteData,
  output logic                   RegWrite
);
  logic w_full, w_empty, w_cpu_win, w_pop, w_push;
  key_entry_t w_head;
  // r0 writes never win, so a queued key entry may drain in the same cycle
  assign w_cpu_win = CpuWriteValid && !CpuStall && CpuWriteRegister != REG_ZERO;
  assign w_pop = !w_cpu_win && !w_empty;
  assign KeyReady = Reset_n && !w_full;
  assign w_push = KeyValid && KeyReady && KeyRegister != REG_ZERO;
  regwrite_arbiter_fifo #(.DEPTH(DEPTH), .W(KEY_ENTRY_W)) u_fifo (
    .clk(Clk),
    .rst_n(Reset_n),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data({KeyRegister, KeyData}),
    .o_data(w_head),
    .o_count(KeyCount),
    .o_full(w_full),
    .o_empty(w_empty)
  );
`ifdef REGWRITE_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;
  assign CpuStall = Reset_n && r_starve == SW'(STARVE_LIMIT);
  // with the FIFO non-empty, a cycle that does not pop is one the CPU won
  always_ff @(posedge Clk) begin
    if (!Reset_n) r_starve <= '0;
    else r_starve <= (w_empty || w_pop) ? '0 : r_starve + 1'b1;
  end
`else
  assign CpuStall = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      RegWrite <= 1'b0;
      WriteRegister <= REG_ZERO;
      WriteData <= '0;
    end else begin
      RegWrite <= w_cpu_win || w_pop;
      if (w_cpu_win) begin
        WriteRegister <= CpuWriteRegister;
        WriteData <= CpuWriteData;
      end else if (w_pop) begin
        WriteRegister <= w_head.addr;
        WriteData <= w_head.data;
      end
    end
  end
endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed and random checks of regwrite_arbiter against a queue-based model.
module tb_regwrite_arbiter;
`ifdef REGWRITE_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  logic Clk = 1'b0, Reset_n, CpuWriteValid, KeyValid;
  logic [4:0] CpuWriteRegister, KeyRegister, WriteRegister;
  logic [31:0] CpuWriteData, KeyData, WriteData;
  logic CpuStall, KeyReady, RegWrite;
  logic [2:0] KeyCount;
  int compared = 0, mismatched = 0;
  logic [36:0] mq[$];
  logic m_we = 1'b0;
  logic [4:0] m_wr = '0;
  logic [31:0] m_wd = '0;
  int m_starve = 0;
  logic last_stall;
  always #5 Clk = ~Clk;
  regwrite_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .CpuWriteValid(CpuWriteValid), .CpuWriteRegister(CpuWriteRegister),
    .CpuWriteData(CpuWriteData), .CpuStall(CpuStall),
    .KeyValid(KeyValid), .KeyReady(KeyReady), .KeyRegister(KeyRegister),
    .KeyData(KeyData), .KeyCount(KeyCount),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic rn, input logic cv, input logic [4:0] cr, input logic [31:0] cd,
                      input logic kv, input logic [4:0] kr, input logic [31:0] kd);
    logic exp_ready, exp_stall, cpu_win, key_iss, push;
    logic [36:0] e;
    Reset_n = rn; CpuWriteValid = cv; CpuWriteRegister = cr; CpuWriteData = cd;
    KeyValid = kv; KeyRegister = kr; KeyData = kd;
    #1;
    exp_ready = rn && mq.size() < DEPTH;
    exp_stall = GUARD && rn && m_starve == LIMIT;
    last_stall = CpuStall;
    chk("KeyReady", KeyReady, exp_ready);
    chk("CpuStall", CpuStall, exp_stall);
    if (!rn) begin
      mq.delete();
      m_we = 0; m_wr = 0; m_wd = 0; m_starve = 0;
    end else begin
      cpu_win = cv && !exp_stall && cr != 0;
      key_iss = !cpu_win && mq.size() > 0;
      push = kv && exp_ready && kr != 0;
      if (GUARD) m_starve = (mq.size() == 0 || key_iss) ? 0 : m_starve + 1;
      m_we = cpu_win || key_iss;
      if (cpu_win) begin
        m_wr = cr; m_wd = cd;
      end else if (key_iss) begin
        e = mq.pop_front();
        m_wr = e[36:32]; m_wd = e[31:0];
      end
      if (push) mq.push_back({kr, kd});
    end
    @(posedge Clk);
    #1;
    chk("RegWrite", RegWrite, m_we);
    chk("WriteRegister", WriteRegister, m_wr);
    chk("WriteData", WriteData, m_wd);
    chk("KeyCount", KeyCount, mq.size());
    chk("NoWriteR0", RegWrite && WriteRegister == 0, 0);
  endtask
  initial begin
    // reset with both sources requesting
    step(0, 1, 5, 32'h55, 1, 6, 32'h66);
    step(0, 1, 5, 32'h55, 1, 6, 32'h66);
    chk("T1RegWrite", RegWrite, 0);
    chk("T1KeyCount", KeyCount, 0);
    chk("T1WriteData", WriteData, 0);
    // CPU write
    step(1, 1, 2, 15, 0, 0, 0);
    chk("T2Write", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd2, 32'd15});
    // keyboard write, two-cycle latency
    step(1, 0, 0, 0, 1, 10, 8);
    chk("T3Count1", KeyCount, 1);
    chk("T3NoWrite", RegWrite, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("T3Write", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd10, 32'd8});
    chk("T3Count0", KeyCount, 0);
    // FIFO fills behind continuous CPU traffic, then drains in order
    for (int i = 0; i < 4; i++) step(1, 1, 3, i, 1, 5'(11 + i), 100 + i);
    step(1, 1, 3, 9, 1, 15, 104);
    chk("T4Full", KeyCount, 4);
    chk("T4Ready", KeyReady, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, i < 2, 15, 104);
      chk("T4Order", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'(11 + i), 32'(100 + i)});
    end
    // CPU write to r0 lets the queued key entry through
    step(1, 1, 5, 1, 1, 4, 4);
    step(1, 1, 0, 8, 0, 0, 0);
    chk("T5Key", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd4, 32'd4});
    // starvation behaviour
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 1, 7, 77);
    for (int k = 1; k <= 9; k++) begin
      step(1, 1, 3, k, 0, 0, 0);
      chk("T6Stall", last_stall, GUARD && k == 9);
      if (GUARD && k == 9) chk("T6Key", {WriteRegister, WriteData}, {5'd7, 32'd77});
      else chk("T6Cpu", {WriteRegister, WriteData, KeyCount}, {5'd3, 32'(k), 3'd1});
    end
    step(1, 1, 3, 10, 0, 0, 0);
    chk("T6After", {RegWrite, WriteRegister}, {1'b1, 5'd3});
    // random traffic
    for (int n = 0; n < 800; n++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
           $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
